i2s_tx_master: RTL and testbench
================================

// Module: i2s_tx_master
// PURPOSE
//   Transmit end of the audio path: takes parallel stereo PCM samples over a valid/ready
//   handshake and serialises them as a standard Philips I2S stream. Acts as clock master,
//   generating bit_clk and lr_clk from clk; it is the counterpart of the I2S receiver in
//   the I2S-to-PWM block. Carries one stereo holding register and flags underruns.
// PARAMETERS
//   SAMPLE_W  16  bits per channel slot, MSB first; frame = 2*SAMPLE_W bit_clk periods
//   CLK_DIV   4   clk cycles per bit_clk half-period (>=1); bit_clk = clk/(2*CLK_DIV)
// PORTS
//   clk           in   1         system clock; all logic on its rising edge
//   rst_n         in   1         asynchronous, active-low reset
//   en            in   1         1 = run; 0 = synchronously return serializer to reset state
//   left_sample   in   SAMPLE_W  left PCM word, two's complement
//   right_sample  in   SAMPLE_W  right PCM word, two's complement
//   sample_valid  in   1         left/right pair presented
//   sample_ready  out  1         holding register empty; pair taken when valid&&ready
//   bit_clk       out  1         I2S serial clock
//   lr_clk        out  1         I2S word select: 0 = left, 1 = right
//   sdout         out  1         I2S serial data; changes on bit_clk falling edge
//   underrun      out  1         one-clk pulse when a frame starts with no pair held
// BEHAVIOUR
//   Reset (rst_n=0, async): bit_clk=0, lr_clk=0, sdout=0, underrun=0, sample_ready=1;
//     div_cnt=0; bit position p=2*SAMPLE_W-1; shift reg=0; holding register empty.
//   Divider: div_cnt counts 0..CLK_DIV-1 and wraps; bit_clk toggles when div_cnt==CLK_DIV-1.
//     First rise is CLK_DIV clks after reset release, first fall at 2*CLK_DIV clks.
//   On each bit_clk falling-edge clk (toggle 1->0): p <= (p==2*SAMPLE_W-1) ? 0 : p+1;
//     sdout, lr_clk and shift reg update in that same clk.
//   sdout: p in 0..SAMPLE_W-1 -> left bit (SAMPLE_W-1-p); p in SAMPLE_W..2*SAMPLE_W-1 ->
//     right bit (2*SAMPLE_W-1-p). Output comes from a 2*SAMPLE_W shift reg, MSB out.
//   lr_clk leads data by one bit (I2S): lr_clk=1 for p in SAMPLE_W-1..2*SAMPLE_W-2, else 0.
//   Frame load on the falling edge where p becomes 0: if the holding register is full,
//     the shift reg gets {left,right}, left MSB drives sdout in that clk, and the holding
//     register empties (sample_ready=1 next clk). If empty: shift reg gets 0, sdout=0,
//     underrun=1 for exactly that clk.
//   Handshake: capture when sample_valid&&sample_ready; holding register full next clk,
//     sample_ready=0. Valid with ready=0 has no effect (source holds); no data dropped.
//   Simultaneous capture and frame load in one clk: the load uses the registered state
//     (empty -> underrun, zero frame); the captured pair is kept for the next frame.
//   en=0: divider, p, bit_clk, lr_clk, sdout, shift reg held at reset values; holding
//     register and handshake keep working. en rising restarts timing as after reset.
//   rst_n asserted mid-frame: all state clears immediately; the held pair is discarded.
// STRUCTURE
//   Shared package i2s_pkg: SAMPLE_W default, LEFT=1'b0 / RIGHT=1'b1 word-select encoding;
//     the RX side uses the same package.
//   Sub-module i2s_clk_div (div_cnt + bit_clk toggle; emits rise/fall strobes).
//   Top: holding register + handshake, p counter, shift reg, lr/underrun decode.
// TESTING
//   SAMPLE_W=16, CLK_DIV=4, reset release: bit_clk first rises at clk 4, falls at clk 8;
//     lr_clk=0, sdout=0, underrun pulses at the first frame load.
//   Push L=16'hA5F0, R=16'h0F5A before first load: sampled on bit_clk rises, sdout gives
//     A5F0 then 0F5A MSB first; lr_clk goes 1 one bit before the R MSB, 0 one bit before L.
//   Hold sample_valid=1 with a pair ready every cycle: one capture per frame (every 256
//     clks), ready low between loads, no underrun, no word skipped or repeated.
//   Withhold data for one frame: underrun one clk pulse at that frame's p=0, 32 zero
//     bits; next frame resumes with the pair pushed after it.
//   Assert valid in the same clk as a frame load with the holding register empty:
//     underrun=1, zero frame, that pair goes out in the following frame.
//   Pull rst_n low mid right slot, then en=0 for 10 clks: outputs at reset values at once;
//     after release the timing restarts from clk 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions for the TX master and RX side: slot width default and word-select encoding.
package i2s_pkg;

  localparam int SAMPLE_W_DEF = 16;

  typedef enum logic {
    LEFT  = 1'b0,
    RIGHT = 1'b1
  } ws_e;

  // Word select for bit position p: it switches one bit early, so the slot's last bit already shows the next channel.
  function automatic ws_e ws_for_pos(input int p, input int w);
    if (p >= w - 1 && p <= 2 * w - 2) begin
      return RIGHT;
    end
    return LEFT;
  endfunction

endpackage

// File: rtl/i2s_clk_div.sv
// Bit clock generator: divides clk by 2*CLK_DIV and flags the clk cycle in which bit_clk falls.
module i2s_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_clk,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  logic          bit_clk_q, bit_clk_d;
  logic          tick;

  always_comb begin
    tick      = en && (div_cnt_q == DIV_LAST);
    div_cnt_d = div_cnt_q;
    bit_clk_d = bit_clk_q;
    if (!en) begin
      div_cnt_d = '0;
      bit_clk_d = 1'b0;
    end else if (tick) begin
      div_cnt_d = '0;
      bit_clk_d = ~bit_clk_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      bit_clk_q <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      bit_clk_q <= bit_clk_d;
    end
  end

  assign bit_clk = bit_clk_q;
  assign fall    = tick && bit_clk_q;

endmodule

// File: rtl/i2s_tx_master.sv
// I2S transmit master: one-pair holding register behind a valid/ready port, serialised
// MSB-first as Philips I2S with locally generated bit_clk and lr_clk.
module i2s_tx_master import i2s_pkg::*; #(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int CLK_DIV  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [SAMPLE_W-1:0] left_sample,
  input  logic [SAMPLE_W-1:0] right_sample,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bit_clk,
  output logic                lr_clk,
  output logic                sdout,
  output logic                underrun
);

  localparam int FW = 2 * SAMPLE_W;
  localparam int PW = $clog2(FW);
  localparam logic [PW-1:0] P_LAST = PW'(FW - 1);

  logic                bit_fall;
  logic                capture;
  logic                load;
  logic [PW-1:0]       p_q, p_d;
  logic [FW-1:0]       shift_q, shift_d;
  ws_e                 lr_q, lr_d;
  logic                underrun_q, underrun_d;
  logic                full_q, full_d;
  logic [SAMPLE_W-1:0] hold_l_q, hold_l_d;
  logic [SAMPLE_W-1:0] hold_r_q, hold_r_d;

  i2s_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .bit_clk(bit_clk),
    .fall   (bit_fall)
  );

  always_comb begin
    capture    = sample_valid && !full_q;
    load       = bit_fall && (p_q == P_LAST);
    p_d        = p_q;
    shift_d    = shift_q;
    lr_d       = lr_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_l_d   = hold_l_q;
    hold_r_d   = hold_r_q;

    if (!en) begin
      p_d     = P_LAST;
      shift_d = '0;
      lr_d    = LEFT;
    end else if (bit_fall) begin
      p_d  = load ? '0 : p_q + 1'b1;
      lr_d = ws_for_pos(32'(p_d), SAMPLE_W);
      if (load) begin
        shift_d    = full_q ? {hold_l_q, hold_r_q} : '0;
        underrun_d = !full_q;
      end else begin
        shift_d = {shift_q[FW-2:0], 1'b0};
      end
    end

    // The load sees only the registered holding state; a pair captured in the same clk waits a frame.
    if (load && full_q) begin
      full_d = 1'b0;
    end else if (capture) begin
      full_d   = 1'b1;
      hold_l_d = left_sample;
      hold_r_d = right_sample;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q        <= P_LAST;
      shift_q    <= '0;
      lr_q       <= LEFT;
      underrun_q <= 1'b0;
      full_q     <= 1'b0;
      hold_l_q   <= '0;
      hold_r_q   <= '0;
    end else begin
      p_q        <= p_d;
      shift_q    <= shift_d;
      lr_q       <= lr_d;
      underrun_q <= underrun_d;
      full_q     <= full_d;
      hold_l_q   <= hold_l_d;
      hold_r_q   <= hold_r_d;
    end
  end

  assign sample_ready = !full_q;
  assign sdout        = shift_q[FW-1];
  assign lr_clk       = lr_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_tx_master.sv
// Scoreboard bench for i2s_tx_master: expected frames come from a frame-level timing model,
// a monitor rebuilds frames from the serial outputs and compares them.
module tb_i2s_tx_master;

  localparam int SW = 16;
  localparam int CD = 4;
  localparam int FW = 2 * SW;
  localparam int FR = FW * 2 * CD;
  localparam int L0 = 2 * CD;
  localparam int NP = 14;
  localparam logic [31:0] LR_PATTERN = 32'h0001_FFFE;

  typedef struct {
    logic [31:0] data;
    bit          urun;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b1;
  logic [SW-1:0] left_sample = '0;
  logic [SW-1:0] right_sample = '0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic          bit_clk;
  logic          lr_clk;
  logic          sdout;
  logic          underrun;

  int     checks = 0;
  int     passes = 0;
  int     cyc = 0;
  int     base = 0;
  frame_t exp_q[$];

  int            p_arr[NP];
  int            a_arr[NP];
  logic [SW-1:0] l_arr[NP];
  logic [SW-1:0] r_arr[NP];

  i2s_tx_master #(
    .SAMPLE_W(SW),
    .CLK_DIV (CD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .bit_clk     (bit_clk),
    .lr_clk      (lr_clk),
    .sdout       (sdout),
    .underrun    (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int rel();
    return cyc - base;
  endfunction

  function automatic int lde(input int k);
    return L0 + FR * k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic wait_until(input int t);
    while (rel() < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives the scheduled pairs with valid held until the handshake completes.
  task automatic drive_pairs();
    for (int j = 0; j < NP; j++) begin
      int  acc;
      logic r;
      wait_until(p_arr[j] - 1);
      left_sample  = l_arr[j];
      right_sample = r_arr[j];
      sample_valid = 1'b1;
      acc = -1;
      for (int t = 0; t < 1000; t++) begin
        @(negedge clk);
        r = sample_ready;
        @(posedge clk);
        #1;
        if (r) begin
          acc = rel();
          break;
        end
      end
      sample_valid = 1'b0;
      check($sformatf("accept_edge[%0d]", j), acc, a_arr[j]);
      $display("pair %0d L=%h R=%h accepted at edge %0d (model %0d)", j, l_arr[j], r_arr[j], acc, a_arr[j]);
    end
  endtask

  // Rebuilds frames from sdout/lr_clk sampled at bit_clk rises and pops the scoreboard per frame.
  task automatic run_monitor(input int nframes);
    int          n, k, i;
    int          done = 0;
    int          clk_err = 0;
    int          stray = 0;
    bit          us[64];
    logic [31:0] dw = '0;
    logic [31:0] lw = '0;
    frame_t      e;
    for (int x = 0; x < 64; x++) us[x] = 1'b0;
    while (done < nframes) begin
      @(posedge clk);
      #1;
      n = rel();
      if (bit_clk !== (((n / CD) % 2) == 1)) clk_err++;
      if (underrun === 1'b1) begin
        if (n >= L0 && ((n - L0) % FR) == 0 && ((n - L0) / FR) < 64) us[(n - L0) / FR] = 1'b1;
        else stray++;
      end else if (underrun !== 1'b0) begin
        stray++;
      end
      if (n == CD) check("pre_frame_idle", {30'd0, lr_clk, sdout}, 32'd0);
      if (n > L0 && ((n - L0) % (2 * CD)) == CD) begin
        k = (n - L0) / FR;
        i = ((n - L0) % FR) / (2 * CD);
        dw[31-i] = sdout;
        lw[31-i] = lr_clk;
        if (i == 31) begin
          done++;
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL frame_pop[%0d]: got frame %h with no expected entry", k, dw);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("frame_data[%0d]", k), dw, e.data);
            check($sformatf("frame_lr[%0d]", k), lw, LR_PATTERN);
            check($sformatf("frame_underrun[%0d]", k), {31'd0, (k < 64) ? us[k] : 1'b0}, {31'd0, e.urun});
            $display("frame %0d data=%h lr=%h underrun=%0d (expected %h/%0d)", k, dw, lw, us[k], e.data, e.urun);
          end
        end
      end
    end
    check("bit_clk_timing_errors", clk_err, 0);
    check("stray_underrun_pulses", stray, 0);
  endtask

  initial begin
    int     free, prev_a, next_k, p, a, k, d, last_k;
    int     idle_err;
    frame_t f;

    repeat (3) @(posedge clk);
    #1;
    check("reset_bit_clk", {31'd0, bit_clk}, 32'd0);
    check("reset_lr_clk", {31'd0, lr_clk}, 32'd0);
    check("reset_sdout", {31'd0, sdout}, 32'd0);
    check("reset_underrun", {31'd0, underrun}, 32'd0);
    check("reset_ready", {31'd0, sample_ready}, 32'd1);

    // Model: a pair is accepted once presented and the slot is free; it leaves in the first frame loaded strictly after acceptance.
    free = 1; prev_a = 0; next_k = 0; last_k = 0;
    for (int j = 0; j < NP; j++) begin
      if (j == 0) begin
        d = 0;
        l_arr[j] = 16'h8001;
        r_arr[j] = 16'h7FFE;
      end else begin
        if (j <= 5) d = 1;
        else if (j == 6) d = 600;
        else d = $urandom_range(1, 600);
        l_arr[j] = SW'($urandom);
        r_arr[j] = SW'($urandom);
      end
      p = (j == 0) ? L0 : prev_a + d;
      a = (p > free) ? p : free;
      k = (a < L0) ? 0 : (a - L0) / FR + 1;
      while (next_k < k) begin
        f.data = '0; f.urun = 1'b1;
        exp_q.push_back(f);
        next_k++;
      end
      f.data = {l_arr[j], r_arr[j]}; f.urun = 1'b0;
      exp_q.push_back(f);
      next_k = k + 1;
      free = lde(k) + 1;
      prev_a = a;
      p_arr[j] = p;
      a_arr[j] = a;
      last_k = k;
    end
    f.data = '0; f.urun = 1'b1;
    exp_q.push_back(f);

    rst_n = 1'b1;
    base = cyc;
    fork
      drive_pairs();
      run_monitor(last_k + 2);
    join

    // A pair captured mid-frame must be discarded by an asynchronous reset in the right slot.
    wait_until(lde(last_k + 2) + 9);
    left_sample  = 16'hDEAD;
    right_sample = 16'hBEEF;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    wait_until(lde(last_k + 2) + 200);
    check("ready_low_while_held", {31'd0, sample_ready}, 32'd0);
    check("lr_right_before_reset", {31'd0, lr_clk}, 32'd1);
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    check("async_reset_bit_clk", {31'd0, bit_clk}, 32'd0);
    check("async_reset_lr_clk", {31'd0, lr_clk}, 32'd0);
    check("async_reset_sdout", {31'd0, sdout}, 32'd0);
    check("async_reset_underrun", {31'd0, underrun}, 32'd0);
    check("async_reset_ready", {31'd0, sample_ready}, 32'd1);

    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    left_sample  = 16'hA5F0;
    right_sample = 16'h0F5A;
    sample_valid = 1'b1;
    idle_err = 0;
    for (int t = 0; t < 10; t++) begin
      @(posedge clk);
      #1;
      if (t == 0) sample_valid = 1'b0;
      if ({bit_clk, lr_clk, sdout, underrun} !== 4'b0000) idle_err++;
    end
    check("en_low_outputs_idle", idle_err, 0);
    check("en_low_handshake_captured", {31'd0, sample_ready}, 32'd0);
    f.data = {16'hA5F0, 16'h0F5A}; f.urun = 1'b0;
    exp_q.push_back(f);
    f.data = '0; f.urun = 1'b1;
    exp_q.push_back(f);

    en = 1'b1;
    base = cyc;
    run_monitor(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
